mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage ARM64 pipeline. Sits between the EX/MEM register and the MEM/WB pipeline register, and produces mem_rd, mem_regwrite and mem_memtoRegOut for MEM/WB.
- Runs LDUR/STUR-family accesses (byte, half, word and doubleword, with zero- or sign-extension) against a 64-bit data memory using a req/ack handshake.
- Asserts stall to freeze upstream stages while an access is in flight.

Parameters:
- TIMEOUT, default 64: maximum cycles dmem_req may wait for dmem_ack before a fault is declared (must be ≥2).

Ports:
- clk  in  1  clock
- resetl  in  1  reset, synchronous, active-low
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_rd  in  5  destination register
- ex_regwrite  in  1  instruction writes rd
- ex_memread  in  1  load
- ex_memwrite  in  1  store
- ex_size  in  2  0=byte, 1=half, 2=word, 3=dword
- ex_signext  in  1  sign-extend load result
- ex_alu_result  in  64  effective address, or the result for non-memory ops
- ex_store_data  in  64  store source (right-aligned)
- dmem_req  out  1  access request (registered)
- dmem_we  out  1  write enable (registered)
- dmem_addr  out  64  doubleword-aligned address (registered)
- dmem_wdata  out  64  lane-shifted write data (registered)
- dmem_be  out  8  byte enables (registered)
- dmem_ack  in  1  access complete; dmem_rdata valid on the same cycle
- dmem_rdata  in  64  read doubleword
- stall  out  1  hold IF/ID/EX and EX/MEM
- mem_rd  out  5  to MEM/WB
- mem_regwrite  out  1  to MEM/WB
- mem_memtoRegOut  out  64  to MEM/WB
- mem_fault  out  1  sticky: misaligned access or timeout

Behaviour:
- Reset (resetl=0 at posedge):
  - state=IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, the load buffer, the timeout counter and mem_fault all clear to 0.
  - Reset mid-access drops dmem_req on that edge and discards the access.
- Definitions:
  - memop = ex_valid & (ex_memread | ex_memwrite).
  - misaligned = (ex_alu_result[2:0] & ((1<<ex_size)-1)) != 0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If memop & !misaligned:
    - stall=1.
    - Next edge: dmem_req=1, dmem_we=ex_memwrite, dmem_addr={ex_alu_result[63:3],3'b0}.
    - dmem_be = ((1<<(1<<ex_size))-1) << ex_alu_result[2:0].
    - dmem_wdata = ex_store_data << (8*ex_alu_result[2:0]).
    - Counter cleared; go to REQ.
  - If memop & misaligned:
    - No request, stall=0, mem_regwrite=0.
    - mem_fault set at next edge.
  - Otherwise (non-memory op):
    - stall=0, mem_memtoRegOut=ex_alu_result, mem_regwrite=ex_valid & ex_regwrite.
    - Zero-latency pass-through.
- REQ:
  - stall=1. dmem_req is held high and the request fields are held stable until the edge that samples dmem_ack=1.
  - On dmem_ack, at that edge:
    - Load buffer = extend(dmem_rdata >> 8*addr[2:0], size, signext).
    - dmem_req=0; go to DONE.
  - Counter increments each REQ cycle without ack. When it reaches TIMEOUT-1 without ack:
    - dmem_req=0, mem_fault=1, timeout flag set; go to DONE.
- DONE:
  - stall=0, mem_rd=ex_rd.
  - Load: mem_memtoRegOut = load buffer, mem_regwrite = ex_regwrite & !timeout.
  - Store: mem_memtoRegOut = ex_alu_result, mem_regwrite = 0.
  - Next edge: unconditionally go to IDLE. The instruction leaves on this edge, so DONE never re-launches.
- mem_rd always equals ex_rd.
- Minimum memory-op latency: 3 cycles (IDLE→REQ→DONE) with ack on the first REQ cycle, giving 2 stall cycles.
- Extension rules:
  - byte/half/word: zero-extend, or replicate bit 7/15/31 when signext.
  - dword: passthrough; ex_signext is ignored.
- dmem_ack outside REQ is ignored.

Decomposition:
- Shared package pipe_pkg holds the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the FSM state typedef.
- One sub-module, load_align_ext: combinational shift plus zero/sign-extension (rdata, offset, size, signext → 64-bit result). It is reused by the store-lane logic via its shift.

Test Plan:
- ALU op, ex_alu_result=0x1234, regwrite=1 → same cycle: stall=0, mem_memtoRegOut=0x1234, mem_regwrite=1, dmem_req never asserted.
- LDURB, addr 0x1005, rdata=0x0000_8000_0000_0000, signext=1, ack in first REQ cycle → be=0x20, dmem_addr=0x1000, 2 stall cycles, DONE result=0xFFFF_FFFF_FFFF_FF80.
- STURH, addr 0x2002, store_data=0xABCD, ack after 3 cycles → we=1, be=0x0C, wdata=0x0000_0000_ABCD_0000, stall held 4 cycles, mem_regwrite=0.
- LDUR (dword) at addr 0x3004 → mem_fault=1, no dmem_req, mem_regwrite=0, stall=0.
- Load with dmem_ack held 0, TIMEOUT=4 → dmem_req falls after 4 REQ cycles, mem_fault=1, DONE has mem_regwrite=0, returns to IDLE.
- resetl=0 during REQ → next edge: dmem_req=0, state IDLE, mem_fault=0; a following ALU op passes through normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: access size encodings, MEM FSM states, byte-enable helper.
package pipe_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } mem_state_t;

   // One enable bit per byte of the access, moved to the addressed lane.
   function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] offset);
      logic [7:0] base;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         SZ_W:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << offset;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
      logic [2:0] low_mask;
      case (size)
         SZ_B:    low_mask = 3'b000;
         SZ_H:    low_mask = 3'b001;
         SZ_W:    low_mask = 3'b011;
         default: low_mask = 3'b111;
      endcase
      return (offset & low_mask) != 3'b000;
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_be;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_access_stage_load_align_ext.sv
// Byte-lane alignment for loads (right shift + zero/sign extension) and stores (left shift).
// Purely combinational, no flow control.
module load_align_ext
   import pipe_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [63:0] st_data,
   input  logic [2:0]  offset,
   input  logic [1:0]  size,
   input  logic        signext,
   output logic [63:0] result,
   output logic [63:0] st_lane
);

   logic [5:0]  shamt;
   logic [63:0] shifted;

   assign shamt   = {offset, 3'b000};
   assign shifted = rdata >> shamt;
   assign st_lane = st_data << shamt;

   always_comb begin
      result = shifted;
      case (size)
         SZ_B:    result = {{56{signext & shifted[7]}},  shifted[7:0]};
         SZ_H:    result = {{48{signext & shifted[15]}}, shifted[15:0]};
         SZ_W:    result = {{32{signext & shifted[31]}}, shifted[31:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores over the req/ack bus, min 3 cycles (2 stall cycles) per memory op,
// non-memory ops pass through with zero latency; stall freezes upstream while an access is in flight.
module mem_access_stage
   import pipe_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                resetl,
   input  logic                ex_valid,
   input  logic [4:0]          ex_rd,
   input  logic                ex_regwrite,
   input  logic                ex_memread,
   input  logic                ex_memwrite,
   input  logic [1:0]          ex_size,
   input  logic                ex_signext,
   input  logic [63:0]         ex_alu_result,
   input  logic [63:0]         ex_store_data,
   mem_access_stage_if.master  dmem,
   output logic                stall,
   output logic [4:0]          mem_rd,
   output logic                mem_regwrite,
   output logic [63:0]         mem_memtoRegOut,
   output logic                mem_fault
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   mem_state_t    state, state_nxt;
   logic [CW-1:0] cnt;
   logic          timeout;
   logic [63:0]   load_buf;
   logic          memop, mis;
   logic [63:0]   ld_res, st_lane;

   assign memop = ex_valid & (ex_memread | ex_memwrite);
   assign mis   = misaligned(ex_size, ex_alu_result[2:0]);

   // EX/MEM is frozen during the access, so the offset stays valid until ack.
   load_align_ext u_align (
      .rdata   (dmem.dmem_rdata),
      .st_data (ex_store_data),
      .offset  (ex_alu_result[2:0]),
      .size    (ex_size),
      .signext (ex_signext),
      .result  (ld_res),
      .st_lane (st_lane)
   );

   always_ff @(posedge clk) begin
      if (!resetl) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (memop && !mis) state_nxt = ST_REQ;
         ST_REQ:  if (dmem.dmem_ack || cnt == CNT_LAST) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      stall           = 1'b0;
      mem_rd          = ex_rd;
      mem_regwrite    = 1'b0;
      mem_memtoRegOut = ex_alu_result;
      case (state)
         ST_IDLE: begin
            if (memop) stall = !mis;
            else       mem_regwrite = ex_valid & ex_regwrite;
         end
         ST_REQ: stall = 1'b1;
         ST_DONE: begin
            if (ex_memread) begin
               mem_memtoRegOut = load_buf;
               mem_regwrite    = ex_regwrite & !timeout;
            end
         end
         default: stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetl) begin
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_wdata <= '0;
         dmem.dmem_be    <= '0;
         load_buf        <= '0;
         cnt             <= '0;
         timeout         <= 1'b0;
         mem_fault       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (memop && !mis) begin
                  dmem.dmem_req   <= 1'b1;
                  dmem.dmem_we    <= ex_memwrite;
                  dmem.dmem_addr  <= {ex_alu_result[63:3], 3'b000};
                  dmem.dmem_be    <= be_mask(ex_size, ex_alu_result[2:0]);
                  dmem.dmem_wdata <= st_lane;
                  cnt             <= '0;
                  timeout         <= 1'b0;
               end else if (memop && mis) begin
                  mem_fault <= 1'b1;
               end
            end
            ST_REQ: begin
               if (dmem.dmem_ack) begin
                  load_buf      <= ld_res;
                  dmem.dmem_req <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  dmem.dmem_req <= 1'b0;
                  mem_fault     <= 1'b1;
                  timeout       <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DONE: timeout <= 1'b0;
            default: timeout <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed checks of the MEM stage: pass-through, aligned loads/stores, misalignment, timeout, reset mid-access.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        resetl;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_signext;
   logic [4:0]  ex_rd;
   logic [1:0]  ex_size;
   logic [63:0] ex_alu_result, ex_store_data;
   logic        stall, mem_regwrite, mem_fault;
   logic [4:0]  mem_rd;
   logic [63:0] mem_memtoRegOut;
   int          n_assert = 0;
   int          n_fail   = 0;

   mem_access_stage_if dif ();

   mem_access_stage #(.TIMEOUT(4)) dut (
      .clk             (clk),
      .resetl          (resetl),
      .ex_valid        (ex_valid),
      .ex_rd           (ex_rd),
      .ex_regwrite     (ex_regwrite),
      .ex_memread      (ex_memread),
      .ex_memwrite     (ex_memwrite),
      .ex_size         (ex_size),
      .ex_signext      (ex_signext),
      .ex_alu_result   (ex_alu_result),
      .ex_store_data   (ex_store_data),
      .dmem            (dif),
      .stall           (stall),
      .mem_rd          (mem_rd),
      .mem_regwrite    (mem_regwrite),
      .mem_memtoRegOut (mem_memtoRegOut),
      .mem_fault       (mem_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic v, input logic rw, input logic rd_op, input logic wr_op,
                         input logic [1:0] sz, input logic sx, input logic [63:0] a,
                         input logic [63:0] sd, input logic [4:0] rd);
      ex_valid = v; ex_regwrite = rw; ex_memread = rd_op; ex_memwrite = wr_op;
      ex_size = sz; ex_signext = sx; ex_alu_result = a; ex_store_data = sd; ex_rd = rd;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetl = 1'b0;
      dif.dmem_ack = 1'b0;
      dif.dmem_rdata = '0;
      set_op(0, 0, 0, 0, 2'd0, 0, 64'h0, 64'h0, 5'd0);
      tick(); tick();
      chk("rst_req", dif.dmem_req, 1'b0);
      chk("rst_we", dif.dmem_we, 1'b0);
      chk("rst_be", dif.dmem_be, 8'h00);
      chk("rst_addr", dif.dmem_addr, 64'h0);
      chk("rst_wdata", dif.dmem_wdata, 64'h0);
      chk("rst_fault", mem_fault, 1'b0);
      chk("rst_stall", stall, 1'b0);
      resetl = 1'b1;

      // ALU pass-through
      tick();
      set_op(1, 1, 0, 0, 2'd3, 0, 64'h1234, 64'h0, 5'd5);
      chk("alu_stall", stall, 1'b0);
      chk("alu_res", mem_memtoRegOut, 64'h1234);
      chk("alu_rw", mem_regwrite, 1'b1);
      chk("alu_rd", mem_rd, 5'd5);
      tick();
      chk("alu_noreq", dif.dmem_req, 1'b0);

      // LDURB signed, ack on first REQ cycle
      set_op(1, 1, 1, 0, 2'd0, 1, 64'h1005, 64'h0, 5'd7);
      chk("ldb_stall0", stall, 1'b1);
      tick();
      chk("ldb_req", dif.dmem_req, 1'b1);
      chk("ldb_we", dif.dmem_we, 1'b0);
      chk("ldb_addr", dif.dmem_addr, 64'h1000);
      chk("ldb_be", dif.dmem_be, 8'h20);
      chk("ldb_stall1", stall, 1'b1);
      dif.dmem_ack = 1'b1;
      dif.dmem_rdata = 64'h0000_8000_0000_0000;
      tick();
      dif.dmem_ack = 1'b0;
      chk("ldb_reqdrop", dif.dmem_req, 1'b0);
      chk("ldb_stall2", stall, 1'b0);
      chk("ldb_res", mem_memtoRegOut, 64'hFFFF_FFFF_FFFF_FF80);
      chk("ldb_rw", mem_regwrite, 1'b1);
      chk("ldb_rd", mem_rd, 5'd7);
      tick();

      // LDURH unsigned at top lane
      set_op(1, 1, 1, 0, 2'd1, 0, 64'h6006, 64'h0, 5'd9);
      tick();
      chk("ldh_be", dif.dmem_be, 8'hC0);
      dif.dmem_ack = 1'b1;
      dif.dmem_rdata = 64'hFEDC_0000_0000_0000;
      tick();
      dif.dmem_ack = 1'b0;
      chk("ldh_res", mem_memtoRegOut, 64'h0000_0000_0000_FEDC);
      tick();

      // STURH, ack on third REQ cycle: 4 stall cycles
      set_op(1, 0, 0, 1, 2'd1, 0, 64'h2002, 64'hABCD, 5'd3);
      chk("sth_stall0", stall, 1'b1);
      tick();
      chk("sth_req", dif.dmem_req, 1'b1);
      chk("sth_we", dif.dmem_we, 1'b1);
      chk("sth_be", dif.dmem_be, 8'h0C);
      chk("sth_wdata", dif.dmem_wdata, 64'h0000_0000_ABCD_0000);
      chk("sth_addr", dif.dmem_addr, 64'h2000);
      chk("sth_stall1", stall, 1'b1);
      tick();
      chk("sth_stall2", stall, 1'b1);
      chk("sth_reqhold", dif.dmem_req, 1'b1);
      tick();
      chk("sth_stall3", stall, 1'b1);
      dif.dmem_ack = 1'b1;
      tick();
      dif.dmem_ack = 1'b0;
      chk("sth_stall4", stall, 1'b0);
      chk("sth_rw", mem_regwrite, 1'b0);
      chk("sth_res", mem_memtoRegOut, 64'h2002);
      chk("sth_reqdrop", dif.dmem_req, 1'b0);
      chk("sth_nofault", mem_fault, 1'b0);
      tick();

      // Misaligned LDUR
      set_op(1, 1, 1, 0, 2'd3, 0, 64'h3004, 64'h0, 5'd4);
      chk("mis_stall", stall, 1'b0);
      chk("mis_rw", mem_regwrite, 1'b0);
      tick();
      chk("mis_noreq", dif.dmem_req, 1'b0);
      chk("mis_fault", mem_fault, 1'b1);
      set_op(0, 0, 0, 0, 2'd0, 0, 64'h0, 64'h0, 5'd0);
      tick();

      // Load timeout with TIMEOUT=4
      set_op(1, 1, 1, 0, 2'd2, 0, 64'h4000, 64'h0, 5'd6);
      tick();
      chk("to_req1", dif.dmem_req, 1'b1);
      tick(); tick(); tick();
      chk("to_req4", dif.dmem_req, 1'b1);
      chk("to_stall4", stall, 1'b1);
      tick();
      chk("to_reqdrop", dif.dmem_req, 1'b0);
      chk("to_stall", stall, 1'b0);
      chk("to_rw", mem_regwrite, 1'b0);
      chk("to_fault", mem_fault, 1'b1);
      tick();
      set_op(1, 1, 0, 0, 2'd0, 0, 64'h55, 64'h0, 5'd2);
      chk("to_idle_res", mem_memtoRegOut, 64'h55);
      chk("to_idle_rw", mem_regwrite, 1'b1);
      tick();

      // Reset during REQ
      set_op(1, 1, 1, 0, 2'd3, 0, 64'h5000, 64'h0, 5'd8);
      tick();
      chk("rr_req", dif.dmem_req, 1'b1);
      resetl = 1'b0;
      tick();
      chk("rr_reqdrop", dif.dmem_req, 1'b0);
      chk("rr_fault", mem_fault, 1'b0);
      resetl = 1'b1;
      set_op(1, 1, 0, 0, 2'd0, 0, 64'hBEEF, 64'h0, 5'd1);
      chk("rr_alu_stall", stall, 1'b0);
      chk("rr_alu_res", mem_memtoRegOut, 64'hBEEF);
      chk("rr_alu_rw", mem_regwrite, 1'b1);
      tick();
      chk("rr_alu_noreq", dif.dmem_req, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
